// File: rtl/branch_predict_resolver.sv
// branch_predict_resolver: EX-stage branch condition resolve, registered redirect/mispredict,
// PC-indexed saturating-counter direction predictor and branch/mispredict perf counters.
module branch_predict_resolver #(
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic              init_busy,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [2:0]        branch,
    input  logic              zero,
    input  logic              sign,
    input  logic              pred_in,
    input  logic [ADDR_W-1:0] target_pc,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [PERF_W-1:0] branch_count,
    output logic [PERF_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  bht_q [BHT_ENTRIES];
    logic              branch_taken_q, branch_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0] branch_count_q, branch_count_d;
    logic [PERF_W-1:0] mispred_count_q, mispred_count_d;

    logic [7:0]        cond_vec;
    logic              cond, active;
    logic [IDX_W-1:0]  lidx, ridx, bht_widx;
    logic [CNT_W-1:0]  rcnt, upd, bht_wdata;
    logic              bht_we;
    logic              unused_pc_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == INIT) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (idx_q == IDX_W'(BHT_ENTRIES - 1)) ? RUN : INIT;
        end
    end

    always_comb begin
        init_busy = rst | (state_q == INIT);
    end

    // Indexed by branch code: 7 always, 6 ltz, 5 lez, 4 gtz, 3 gez, 2 ne, 1 eq, 0 none.
    always_comb begin
        cond_vec = {1'b1, sign, sign | zero, ~sign & ~zero, ~sign, ~zero, zero, 1'b0};
        cond     = cond_vec[branch];
        active   = resolve_valid & (branch != 3'd0);
        branch_taken_d  = resolve_valid & cond;
        mispredict_d    = active & (cond != pred_in);
        redirect_pc_d   = active ? (cond ? target_pc : resolve_pc + ADDR_W'(4)) : redirect_pc_q;
        branch_count_d  = branch_count_q + PERF_W'(active);
        mispred_count_d = mispred_count_q + PERF_W'(mispredict_d);
    end

    always_comb begin
        lidx       = lookup_pc[IDX_W+1:2];
        ridx       = resolve_pc[IDX_W+1:2];
        rcnt       = bht_q[ridx];
        upd        = cond ? ((rcnt == '1) ? rcnt : rcnt + CNT_W'(1))
                          : ((rcnt == '0) ? rcnt : rcnt - CNT_W'(1));
        bht_we     = ~rst & ((state_q == INIT) | active);
        bht_widx   = (state_q == INIT) ? idx_q : ridx;
        bht_wdata  = (state_q == INIT) ? CNT_W'(1) : upd;
        pred_taken = ~init_busy & bht_q[lidx][CNT_W-1];
    end

    assign unused_pc_bits = ^{lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0]};

    // Table has no reset of its own; INIT sweeps every entry after rst.
    always_ff @(posedge clk) begin
        if (bht_we) bht_q[bht_widx] <= bht_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_taken_q  <= 1'b0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            branch_taken_q  <= branch_taken_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch_taken  = branch_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;
endmodule
